// File: rtl/cam_ctrl_requester.sv
// Camera power requester: turns host on/off commands into a dwell-limited
// control level for the camera controller, confirms the request against
// synchronised power/reset feedback, and latches a fault on confirmation timeout.
module cam_ctrl_requester #(
  parameter int unsigned MIN_DWELL = 1000,
  parameter int unsigned TIMEOUT   = 100000
) (
  input  logic sclk_i,
  input  logic reset_n_i,
  input  logic cmd_valid_i,
  input  logic cmd_on_i,
  output logic cmd_ready_o,
  output logic cam_ctrl_o,
  input  logic cam_pwr_en_i,
  input  logic cam_reset_i,
  output logic cam_on_o,
  output logic busy_o,
  output logic fault_o,
  input  logic fault_clr_i
);

  typedef enum logic [2:0] {
    S_OFF,
    S_ON_WAIT,
    S_ON,
    S_OFF_WAIT,
    S_FAULT
  } state_t;

  localparam logic [23:0] CNT_MAX = 24'hFF_FFFF;
  localparam logic [23:0] CNT_ONE = 24'd1;
  localparam logic [23:0] DWELL_L = 24'(MIN_DWELL);
  localparam logic [24:0] TO_L    = 25'(TIMEOUT);

  // Feedback synchronisers
  logic r_pwr_meta, r_pwr_sync;
  logic r_rst_meta, r_rst_sync;

  // Control state
  state_t      r_state;
  logic        r_cam_ctrl;
  logic        r_fault;
  logic        r_ready;
  logic        r_busy;
  logic [23:0] r_dwell_cnt;
  logic [23:0] r_to_cnt;

  // Next-state values
  state_t      w_state_nxt;
  logic        w_ctrl_nxt;
  logic        w_fault_nxt;
  logic        w_dwell_clr;
  logic        w_to_clr;
  logic        w_to_fault;
  logic [23:0] w_dwell_nxt;
  logic [23:0] w_to_nxt;
  logic        w_ready_nxt;
  logic        w_busy_nxt;

  logic w_up, w_down, w_confirm, w_dwell_exp, w_to_hit, w_accept;

  // Two-flop synchronisers for the asynchronous camera feedback
  // NOTE: synchroniser flops take the async reset too, so a stale "up" can never
  // survive a reset and confirm a request that was never made.
  always_ff @(posedge sclk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_pwr_meta <= 1'b0;
      r_pwr_sync <= 1'b0;
      r_rst_meta <= 1'b0;
      r_rst_sync <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge value,
      // which is what turns these four lines into two distinct stages.
      r_pwr_meta <= cam_pwr_en_i;
      r_pwr_sync <= r_pwr_meta;
      r_rst_meta <= cam_reset_i;
      r_rst_sync <= r_rst_meta;
    end
  end

  assign w_up        = r_pwr_sync & r_rst_sync;
  assign w_down      = ~r_pwr_sync;
  // In OFF_WAIT with the control still high we are waiting for the camera to
  // come back after a dropout, otherwise for it to go down.
  assign w_confirm   = r_cam_ctrl ? w_up : w_down;
  assign w_dwell_exp = (r_dwell_cnt >= DWELL_L);
  assign w_to_hit    = (({1'b0, r_to_cnt} + 25'd1) >= TO_L);
  assign w_accept    = cmd_valid_i & r_ready;

  // Next-state and control-level decode
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that forgot
    // one would otherwise infer a latch.
    w_state_nxt = r_state;
    w_ctrl_nxt  = r_cam_ctrl;
    w_fault_nxt = r_fault;
    w_dwell_clr = 1'b0;
    w_to_clr    = 1'b0;
    w_to_fault  = 1'b0;
    case (r_state)
      S_OFF: begin
        // A redundant off command is accepted and simply falls through.
        if (w_accept && cmd_on_i) begin
          w_state_nxt = S_ON_WAIT;
          w_ctrl_nxt  = 1'b1;
          w_dwell_clr = 1'b1;
          w_to_clr    = 1'b1;
        end
      end
      S_ON_WAIT: begin
        if (w_up && w_dwell_exp) w_state_nxt = S_ON;
        else if (w_to_hit)       w_to_fault  = 1'b1;
      end
      S_ON: begin
        if (w_accept && !cmd_on_i) begin
          w_state_nxt = S_OFF_WAIT;
          w_ctrl_nxt  = 1'b0;
          w_dwell_clr = 1'b1;
          w_to_clr    = 1'b1;
        end else if (!w_up) begin
          // Camera dropped on its own: keep requesting on, give it TIMEOUT to return.
          w_state_nxt = S_OFF_WAIT;
          w_to_clr    = 1'b1;
        end
      end
      S_OFF_WAIT: begin
        if (w_confirm && w_dwell_exp) w_state_nxt = r_cam_ctrl ? S_ON : S_OFF;
        else if (w_to_hit)            w_to_fault  = 1'b1;
      end
      S_FAULT: begin
        if (fault_clr_i) begin
          w_state_nxt = S_OFF;
          w_fault_nxt = 1'b0;
          w_dwell_clr = 1'b1;
        end
      end
      default: w_state_nxt = S_OFF;
    endcase
    if (w_to_fault) begin
      w_state_nxt = S_FAULT;
      w_ctrl_nxt  = 1'b0;
      w_fault_nxt = 1'b1;
      // Dwell restarts only if the control level actually changes.
      w_dwell_clr = r_cam_ctrl;
    end
  end

  assign w_dwell_nxt = w_dwell_clr ? 24'd0 :
                       (r_dwell_cnt == CNT_MAX) ? r_dwell_cnt : r_dwell_cnt + CNT_ONE;
  assign w_to_nxt    = w_to_clr ? 24'd0 :
                       (r_to_cnt == CNT_MAX) ? r_to_cnt : r_to_cnt + CNT_ONE;

  // Handshake/busy flags are registered so they read 0 during reset.
  assign w_ready_nxt = ((w_state_nxt == S_OFF) || (w_state_nxt == S_ON)) &&
                       (w_dwell_nxt >= DWELL_L);
  assign w_busy_nxt  = (w_state_nxt == S_ON_WAIT) || (w_state_nxt == S_OFF_WAIT) ||
                       (w_dwell_nxt < DWELL_L);

  // State, counters and registered outputs
  always_ff @(posedge sclk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state     <= S_OFF;
      r_cam_ctrl  <= 1'b0;
      r_fault     <= 1'b0;
      r_ready     <= 1'b0;
      r_busy      <= 1'b0;
      r_dwell_cnt <= 24'd0;
      r_to_cnt    <= 24'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_cam_ctrl  <= w_ctrl_nxt;
      r_fault     <= w_fault_nxt;
      r_ready     <= w_ready_nxt;
      r_busy      <= w_busy_nxt;
      r_dwell_cnt <= w_dwell_nxt;
      r_to_cnt    <= w_to_nxt;
    end
  end

  assign cmd_ready_o = r_ready;
  assign cam_ctrl_o  = r_cam_ctrl;
  assign cam_on_o    = (r_state == S_ON);
  assign busy_o      = r_busy;
  assign fault_o     = r_fault;

endmodule

// File: tb/tb_cam_ctrl_requester.sv
// Scoreboard bench for cam_ctrl_requester: a timestamp-based reference model
// predicts the outputs after every clock edge; a monitor compares them.
module tb_cam_ctrl_requester;

  localparam int MIN_DWELL = 4;
  localparam int TIMEOUT   = 16;

  logic sclk_i = 1'b0;
  logic reset_n_i = 1'b0;
  logic cmd_valid_i = 1'b0, cmd_on_i = 1'b0, fault_clr_i = 1'b0;
  logic cam_pwr_en_i = 1'b0, cam_reset_i = 1'b0;
  logic cmd_ready_o, cam_ctrl_o, cam_on_o, busy_o, fault_o;

  cam_ctrl_requester #(.MIN_DWELL(MIN_DWELL), .TIMEOUT(TIMEOUT)) dut (
    .sclk_i      (sclk_i),
    .reset_n_i   (reset_n_i),
    .cmd_valid_i (cmd_valid_i),
    .cmd_on_i    (cmd_on_i),
    .cmd_ready_o (cmd_ready_o),
    .cam_ctrl_o  (cam_ctrl_o),
    .cam_pwr_en_i(cam_pwr_en_i),
    .cam_reset_i (cam_reset_i),
    .cam_on_o    (cam_on_o),
    .busy_o      (busy_o),
    .fault_o     (fault_o),
    .fault_clr_i (fault_clr_i)
  );

  always #5 sclk_i = ~sclk_i;

  typedef struct packed {
    logic ready;
    logic ctrl;
    logic on;
    logic busy;
    logic fault;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic act, input logic req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- reference model (timestamps instead of counters) -------
  typedef enum int {MD_OFF, MD_RISING, MD_ON, MD_FALLING, MD_FAULT} mode_e;
  mode_e m_mode;
  bit    m_ctrl, m_fault;
  int    m_cyc;          // clock edges since reset release
  int    m_last_change;  // edge at which the control level last changed
  int    m_deadline;     // edge at which an unconfirmed request faults
  bit    m_pwr_d1, m_pwr_d2, m_rst_d1, m_rst_d2;
  bit    ctrl_hist[8];   // camera emulation: past control levels, [0] newest
  int    cam_lag = 2;

  task automatic model_reset();
    m_mode = MD_OFF; m_ctrl = 0; m_fault = 0;
    m_cyc = 0; m_last_change = 0; m_deadline = 0;
    m_pwr_d1 = 0; m_pwr_d2 = 0; m_rst_d1 = 0; m_rst_d2 = 0;
    for (int i = 0; i < 8; i++) ctrl_hist[i] = 0;
  endtask

  function automatic bit model_dwell_ok();
    return (m_cyc - m_last_change) >= MIN_DWELL;
  endfunction

  function automatic bit model_ready();
    return ((m_mode == MD_OFF) || (m_mode == MD_ON)) && model_dwell_ok();
  endfunction

  function automatic exp_t model_outputs();
    exp_t e;
    e.ready = model_ready();
    e.ctrl  = m_ctrl;
    e.on    = (m_mode == MD_ON);
    e.busy  = (m_mode == MD_RISING) || (m_mode == MD_FALLING) || !model_dwell_ok();
    e.fault = m_fault;
    return e;
  endfunction

  task automatic model_fault(input int e);
    if (m_ctrl) m_last_change = e;
    m_mode = MD_FAULT; m_ctrl = 0; m_fault = 1;
  endtask

  // Advance the model across one clock edge with the given inputs.
  task automatic model_edge(input bit v, input bit on, input bit clr,
                            input bit pwr, input bit rst, output bit acc);
    int e;
    bit up, down, dok;
    e    = m_cyc + 1;
    up   = m_pwr_d2 && m_rst_d2;
    down = !m_pwr_d2;
    dok  = model_dwell_ok();
    acc  = v && model_ready();
    case (m_mode)
      MD_OFF:
        if (acc && on) begin
          m_mode = MD_RISING; m_ctrl = 1; m_last_change = e; m_deadline = e + TIMEOUT;
        end
      MD_RISING:
        if (up && dok) m_mode = MD_ON;
        else if (e >= m_deadline) model_fault(e);
      MD_ON:
        if (acc && !on) begin
          m_mode = MD_FALLING; m_ctrl = 0; m_last_change = e; m_deadline = e + TIMEOUT;
        end else if (!up) begin
          m_mode = MD_FALLING; m_deadline = e + TIMEOUT;
        end
      MD_FALLING:
        if ((m_ctrl ? up : down) && dok) m_mode = m_ctrl ? MD_ON : MD_OFF;
        else if (e >= m_deadline) model_fault(e);
      default:
        if (clr) begin
          m_mode = MD_OFF; m_fault = 0; m_last_change = e;
        end
    endcase
    m_cyc = e;
    m_pwr_d2 = m_pwr_d1; m_pwr_d1 = pwr;
    m_rst_d2 = m_rst_d1; m_rst_d1 = rst;
  endtask

  // ---------------- stimulus helpers (called at a falling edge) ------------
  task automatic step(input bit v, input bit on, input bit clr,
                      input bit pwr, input bit rst, output bit acc);
    cmd_valid_i  = v;
    cmd_on_i     = on;
    fault_clr_i  = clr;
    cam_pwr_en_i = pwr;
    cam_reset_i  = rst;
    model_edge(v, on, clr, pwr, rst, acc);
    exp_q.push_back(model_outputs());
    for (int i = 7; i > 0; i--) ctrl_hist[i] = ctrl_hist[i-1];
    ctrl_hist[0] = m_ctrl;
    @(negedge sclk_i);
  endtask

  task automatic idle(input bit pwr, input int n);
    bit a;
    repeat (n) step(0, 0, 0, pwr, pwr, a);
  endtask

  // Camera follows the requested level with cam_lag cycles of delay.
  task automatic cam_step(input bit v, input bit on, input bit clr,
                          input bit drop, output bit acc);
    bit pwr;
    pwr = ctrl_hist[cam_lag] && !drop;
    step(v, on, clr, pwr, pwr, acc);
  endtask

  task automatic cam_idle(input int n);
    bit a;
    repeat (n) cam_step(0, 0, 0, 0, a);
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 100 && !model_ready(); i++) cam_idle(1);
  endtask

  // ---------------- monitor ------------------------------------------------
  int   mon_cyc = 0;
  int   last_chg = -1;
  logic prev_ctrl = 1'b0;

  always @(posedge sclk_i) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("cmd_ready_o", cmd_ready_o, e.ready);
      check("cam_ctrl_o",  cam_ctrl_o,  e.ctrl);
      check("cam_on_o",    cam_on_o,    e.on);
      check("busy_o",      busy_o,      e.busy);
      check("fault_o",     fault_o,     e.fault);
    end
    if (!reset_n_i) begin
      last_chg  = -1;
      prev_ctrl = 1'b0;
    end else begin
      mon_cyc++;
      if (cam_ctrl_o !== prev_ctrl) begin
        if (last_chg >= 0)
          check("ctrl_dwell_spacing", (mon_cyc - last_chg) >= MIN_DWELL, 1'b1);
        last_chg  = mon_cyc;
        prev_ctrl = cam_ctrl_o;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, cmd_ready_o, 1'b0);
    check({tag, "_ctrl"},  cam_ctrl_o,  1'b0);
    check({tag, "_on"},    cam_on_o,    1'b0);
    check({tag, "_busy"},  busy_o,      1'b0);
    check({tag, "_fault"}, fault_o,     1'b0);
  endtask

  // ---------------- main sequence -----------------------------------------
  initial begin
    bit  a, want;
    int  drop_left;
    model_reset();
    #22;
    check_reset_outputs("reset");
    @(negedge sclk_i);
    reset_n_i = 1'b1;

    // Power on; feedback appears at cycle 6 after the command.
    wait_ready();
    step(1, 1, 0, 0, 0, a);
    for (int i = 1; i < 14; i++) step(0, 0, 0, i >= 6, i >= 6, a);

    // Redundant on in ON, then off with a following camera, stray fault clear,
    // then redundant off in OFF with valid held.
    step(1, 1, 0, 1, 1, a);
    step(1, 1, 0, 1, 1, a);
    cam_lag = 3;
    wait_ready();
    cam_step(1, 0, 0, 0, a);
    cam_idle(4);
    cam_step(0, 0, 1, 0, a);
    cam_idle(12);
    wait_ready();
    repeat (4) cam_step(1, 0, 0, 0, a);

    // Dead camera: timeout fault, clear, dwell before next command.
    wait_ready();
    step(1, 1, 0, 0, 0, a);
    idle(0, 20);
    step(0, 0, 1, 0, 0, a);
    idle(0, 6);

    // In ON, long dropout -> fault; short dropout -> recovers.
    wait_ready();
    cam_step(1, 1, 0, 0, a);
    cam_idle(15);
    repeat (30) cam_step(0, 0, 0, 1, a);
    cam_step(0, 0, 1, 0, a);
    wait_ready();
    cam_step(1, 1, 0, 0, a);
    cam_idle(15);
    repeat (5) cam_step(0, 0, 0, 1, a);
    cam_idle(12);

    // Valid held with alternating payload.
    want = !m_ctrl;
    repeat (150) begin
      cam_step(1, want, 0, 0, a);
      if (a) want = !want;
    end
    cam_idle(20);

    // Reset mid ON_WAIT: control must fall with no clock edge.
    if (m_ctrl) begin
      wait_ready();
      cam_step(1, 0, 0, 0, a);
      cam_idle(15);
    end
    wait_ready();
    step(1, 1, 0, 0, 0, a);
    idle(0, 1);
    #3;
    check("ctrl_before_reset", cam_ctrl_o, m_ctrl);
    reset_n_i = 1'b0;
    cmd_valid_i = 0; cmd_on_i = 0; fault_clr_i = 0; cam_pwr_en_i = 0; cam_reset_i = 0;
    #1;
    check_reset_outputs("async_reset");
    @(negedge sclk_i);
    @(negedge sclk_i);
    model_reset();
    reset_n_i = 1'b1;

    // Randomised traffic with a lagging, occasionally failing camera.
    drop_left = 0;
    for (int c = 0; c < 3000; c++) begin
      bit v, on, clr, drop, pwr, rst;
      if (c % 200 == 0) cam_lag = int'($urandom_range(0, 7));
      v   = ($urandom_range(0, 2) == 0);
      on  = $urandom_range(0, 1) == 1;
      clr = ($urandom_range(0, 19) == 0);
      if (drop_left > 0) begin
        drop_left--;
        drop = 1;
      end else begin
        drop = 0;
        if ($urandom_range(0, 149) == 0) drop_left = int'($urandom_range(1, 35));
      end
      pwr = ctrl_hist[cam_lag] && !drop;
      rst = pwr && ($urandom_range(0, 59) != 0);
      step(v, on, clr, pwr, rst, a);
    end

    #20;
    check_int("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Absolute time bound in case the sequence ever stalls.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/cam_ctrl_requester.md
CAM_CTRL_REQUESTER -- requirements
Module: cam_ctrl_requester

Interface
REQ-001 SHALL have parameter MIN_DWELL, default 1000: minimum cycles cam_ctrl_o holds a level after any change.
REQ-002 SHALL have parameter TIMEOUT, default 100000: maximum cycles allowed for camera feedback to confirm a requested state.
REQ-003 SHALL have port sclk_i, input, 1: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset_n_i, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port cmd_valid_i, input, 1: host command valid.
REQ-006 SHALL have port cmd_on_i, input, 1: command payload (1 = power camera on, 0 = power off).
REQ-007 SHALL have port cmd_ready_o, output, 1: block can accept a command.
REQ-008 SHALL have port cam_ctrl_o, output, 1: control level to the camera controller's control input.
REQ-009 SHALL have port cam_pwr_en_i, input, 1: camera power-enable feedback (asynchronous).
REQ-010 SHALL have port cam_reset_i, input, 1: camera reset feedback, active-low (1 = released), asynchronous.
REQ-011 SHALL have port cam_on_o, output, 1: camera confirmed powered and out of reset.
REQ-012 SHALL have port busy_o, output, 1: sequence or dwell in progress.
REQ-013 SHALL have port fault_o, output, 1: confirmation timeout occurred (sticky).
REQ-014 SHALL have port fault_clr_i, input, 1: single-cycle clear of the fault.

Function
REQ-015 SHALL synchronise cam_pwr_en_i and cam_reset_i through 2 flops each; "up" = synced pwr_en=1 and reset=1; "down" = synced pwr_en=0.
REQ-016 SHALL implement states OFF, ON_WAIT, ON, OFF_WAIT, FAULT.
REQ-017 SHALL use a 24-bit dwell counter and a 24-bit timeout counter, both saturating; parameters SHALL be < 2^24.
REQ-018 SHALL assert cmd_ready_o only in OFF or ON with the dwell counter expired.
REQ-019 SHALL accept a command on a cycle where cmd_valid_i and cmd_ready_o are both 1; cmd_on_i is sampled on that cycle only.
REQ-020 SHALL, for an accepted on-command in OFF, set cam_ctrl_o=1 on the next edge, enter ON_WAIT, and clear both counters.
REQ-021 SHALL, for an accepted off-command in ON, set cam_ctrl_o=0 on the next edge, enter OFF_WAIT, and clear both counters.
REQ-022 SHALL treat a command matching the current state (on in ON, off in OFF) as accepted with no change to cam_ctrl_o, state or counters.
REQ-023 SHALL go from ON_WAIT to ON on the first cycle "up" holds and the dwell has expired; from OFF_WAIT to OFF on the first cycle "down" holds and the dwell has expired.
REQ-024 SHALL enter FAULT from ON_WAIT or OFF_WAIT when the timeout counter reaches TIMEOUT without confirmation, with cam_ctrl_o=0 and fault_o=1 from that edge.
REQ-025 SHALL hold FAULT with cmd_ready_o=0 until fault_clr_i=1, then enter OFF with the dwell counter cleared, so MIN_DWELL applies before the next command.
REQ-026 SHALL ignore fault_clr_i outside FAULT.
REQ-027 SHALL drive cam_on_o=1 only in ON.
REQ-028 SHALL drive busy_o=1 in ON_WAIT, OFF_WAIT, or while the dwell counter is not expired.
REQ-029 SHALL, in ON, move to OFF_WAIT when "up" is lost (camera dropped unexpectedly) and restart the timeout counter; cam_ctrl_o stays 1.
REQ-030 SHALL, in OFF_WAIT with cam_ctrl_o=1 per REQ-029, enter FAULT if "up" has not returned within TIMEOUT.

Reset
REQ-031 SHALL, while reset_n_i=0, asynchronously force: state=OFF, cam_ctrl_o=0, cmd_ready_o=0, cam_on_o=0, busy_o=0, fault_o=0, counters=0, synchronisers=0.
REQ-032 SHALL make the first command acceptable MIN_DWELL cycles after reset deassertion.
REQ-033 SHALL, on reset asserted mid-sequence (any state), drop cam_ctrl_o to 0 immediately without waiting for a clock.

Verification (MIN_DWELL=4, TIMEOUT=16)
REQ-034 After reset: cmd on -> cam_ctrl_o=1 next cycle; feedback "up" at cycle 6 -> cam_on_o=1 two cycles after the synchroniser; cmd_ready_o=1.
REQ-035 No feedback after on-command -> fault_o=1 and cam_ctrl_o=0 at cycle 16; fault_clr_i pulse -> OFF, cmd_ready_o=1 four cycles later.
REQ-036 cmd_valid_i held with alternating on/off -> every cam_ctrl_o change separated by >= 4 cycles; no command lost or duplicated.
REQ-037 In ON, cam_pwr_en_i drops for 30 cycles -> cam_on_o=0, fault_o=1 at 16 cycles; a drop for 5 cycles -> return to ON without fault.
REQ-038 reset_n_i pulled low during ON_WAIT -> cam_ctrl_o=0 with no clock edge; all outputs at reset values.
REQ-039 Redundant off in OFF -> cmd_ready_o stays 1, cam_ctrl_o stays 0, busy_o stays 0.
